// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch front end.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package fetch_unit_pkg;

  localparam int XLEN    = 32;
  localparam int INSTR_W = 32;

  localparam logic [INSTR_W-1:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [XLEN-1:0]    DEFAULT_RESET_PC = 32'h0000_0000;

  // One buffered fetch result: the address and the word read from it.
  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  // Instruction addresses are always word aligned; low bits are dropped.
  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-to-decode handshake bundle carrying {pc, instr} pairs.
// Latency: n/a (wiring only).
// Backpressure: decode holds if_ready low to stall; transfer when if_valid & if_ready.
interface fetch_unit_if;
  import fetch_unit_pkg::*;

  logic               if_valid;
  logic               if_ready;
  logic [XLEN-1:0]    if_pc;
  logic [INSTR_W-1:0] if_instr;

  // Fetch side drives the payload, decode side drives ready.
  modport master (
    output if_valid,
    output if_pc,
    output if_instr,
    input  if_ready
  );

  modport slave (
    input  if_valid,
    input  if_pc,
    input  if_instr,
    output if_ready
  );

endinterface

// File: rtl/fetch_unit_fifo.sv
// Small circular buffer of fetch entries between fetch and decode.
// Latency: a pushed entry appears on head_o the cycle after the push (no bypass).
// Backpressure: push is dropped when full unless a pop happens the same cycle.
module fetch_fifo
  import fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  fetch_entry_t           push_dat_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  output fetch_entry_t           head_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;

  logic do_push;
  logic do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // A pop frees a slot in the same cycle, so push-while-full is legal with a pop.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  // Storage: cleared on reset so the head reads as zero until the first write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (!flush_i && do_push) begin
      mem_q[wr_ptr_q] <= push_dat_i;
    end
  end

  // Pointers and occupancy; flush empties the buffer without touching storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, reads a synchronous instruction memory, buffers results for decode.
// Latency: address issued at edge N, captured at N+1, visible to decode after N+1 (redirect to target: 2 cycles).
// Backpressure: credit based; a fetch is issued only if buffer slots cover buffered plus in-flight words.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  output logic [XLEN-1:0]    Pc_out,
  input  logic [INSTR_W-1:0] Instruction,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_pc,
  fetch_unit_if.master       dec
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int SUM_W = CNT_W + 1;

  // PC presented to memory, plus the address of the word currently in flight.
  logic [XLEN-1:0] pc_out_q;
  logic [XLEN-1:0] pc_out_d;
  logic [XLEN-1:0] fetch_pc_q;
  logic [XLEN-1:0] fetch_pc_d;
  logic            inflight_q;
  logic            inflight_d;

  logic             deq;
  logic             issue;
  logic             capture;
  logic [SUM_W-1:0] credits_used;

  fetch_entry_t     push_dat;
  fetch_entry_t     head;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_full;
  logic             fifo_empty;

  assign Pc_out = pc_out_q;

  assign deq = dec.if_valid & dec.if_ready;

  // Slots that will be occupied after this edge if we do not issue: buffered
  // entries plus the word returning now, minus whatever decode takes now.
  assign credits_used = SUM_W'(fifo_count) + SUM_W'(inflight_q) - SUM_W'(deq);

  // Redirect wins over everything; a new fetch needs a guaranteed free slot.
  assign issue = ~rst & ~redirect_valid & (credits_used < SUM_W'(FIFO_DEPTH));

  // The word returning this cycle is kept only if no redirect is discarding it.
  assign capture = inflight_q & ~redirect_valid;

  assign push_dat = '{pc: fetch_pc_q, instr: Instruction};

  // Next PC and in-flight tracking: redirect, advance on issue, else hold.
  always_comb begin
    pc_out_d   = pc_out_q;
    fetch_pc_d = fetch_pc_q;
    inflight_d = 1'b0;
    if (redirect_valid) begin
      pc_out_d = align_word(redirect_pc);
    end else if (issue) begin
      pc_out_d   = pc_out_q + XLEN'(4);
      fetch_pc_d = pc_out_q;
      inflight_d = 1'b1;
    end
  end

  // PC registers; reset parks the PC on the reset vector with nothing in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_out_q   <= align_word(RESET_PC);
      fetch_pc_q <= '0;
      inflight_q <= 1'b0;
    end else begin
      pc_out_q   <= pc_out_d;
      fetch_pc_q <= fetch_pc_d;
      inflight_q <= inflight_d;
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (capture),
    .push_dat_i (push_dat),
    .pop_i      (deq & ~redirect_valid),
    .flush_i    (redirect_valid),
    .head_o     (head),
    .count_o    (fifo_count),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  assign dec.if_valid = ~fifo_empty;
  assign dec.if_pc    = head.pc;
  assign dec.if_instr = head.instr;

  // Credits must make a capture into a full buffer impossible unless decode pops.
  a_no_overflow : assert property (@(posedge clk) disable iff (rst)
    !(fifo_full && capture && !deq));

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit with a synchronous instruction memory model (word i = A000_0000 + i).
// Latency: n/a (testbench).
// Backpressure: decode ready driven by the stimulus tasks.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] Pc_out, Pc_out2;
  logic [31:0] Instruction = '0;
  logic [31:0] Instruction2 = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        redirect_valid2 = 1'b0;
  logic [31:0] redirect_pc2 = '0;

  int          n_pass = 0;
  int          n_total = 0;
  logic [31:0] exp_pc;

  fetch_unit_if u_if ();
  fetch_unit_if u_if2 ();

  fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .Pc_out(Pc_out), .Instruction(Instruction),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .dec(u_if.master));

  fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(2)) dut_wrap (
    .clk(clk), .rst(rst), .Pc_out(Pc_out2), .Instruction(Instruction2),
    .redirect_valid(redirect_valid2), .redirect_pc(redirect_pc2), .dec(u_if2.master));

  always #5 clk = ~clk;

  // Memory contents as a rule: word index plus a fixed tag.
  function automatic logic [31:0] instr_of(input logic [31:0] addr);
    return 32'hA000_0000 + {2'b00, addr[31:2]};
  endfunction

  // Synchronous-read memories.
  always @(posedge clk) begin
    Instruction  <= instr_of(Pc_out);
    Instruction2 <= instr_of(Pc_out2);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; u_if.if_ready = 1'b0; redirect_valid = 1'b0;
    repeat (3) tick();
    n_total++;
    if (Pc_out !== 32'h0) $display("FAIL reset_pc got=%h want=00000000", Pc_out);
    else n_pass++;
    n_total++;
    if (u_if.if_valid !== 1'b0) $display("FAIL reset_valid got=%b want=0", u_if.if_valid);
    else n_pass++;
    n_total++;
    if ({u_if.if_pc, u_if.if_instr} !== 64'h0)
      $display("FAIL reset_payload got=%h/%h want=0/0", u_if.if_pc, u_if.if_instr);
    else n_pass++;
    rst = 1'b0; u_if.if_ready = 1'b1; exp_pc = 32'h0;
    for (int i = 0; i < 2; i++) begin
      n_total++;
      if (u_if.if_valid !== 1'b0) $display("FAIL startup_gap cyc=%0d got=%b want=0", i, u_if.if_valid);
      else n_pass++;
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      n_total++;
      if (u_if.if_valid !== 1'b1 || u_if.if_pc !== exp_pc || u_if.if_instr !== instr_of(exp_pc))
        $display("FAIL startup_stream got=%b %h %h want=1 %h %h", u_if.if_valid, u_if.if_pc,
                 u_if.if_instr, exp_pc, instr_of(exp_pc));
      else n_pass++;
      exp_pc += 4;
      tick();
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] pc_hold;
    u_if.if_ready = 1'b0;
    pc_hold = '0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i == 1) pc_hold = Pc_out;
    end
    n_total++;
    if (Pc_out !== pc_hold) $display("FAIL stall_pc_frozen got=%h want=%h", Pc_out, pc_hold);
    else n_pass++;
    // Two buffered words ahead of the head means the PC sits two words on.
    n_total++;
    if (Pc_out !== exp_pc + 32'd8) $display("FAIL stall_pc_value got=%h want=%h", Pc_out, exp_pc + 32'd8);
    else n_pass++;
    u_if.if_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      n_total++;
      if (u_if.if_valid !== 1'b1 || u_if.if_pc !== exp_pc || u_if.if_instr !== instr_of(exp_pc))
        $display("FAIL release_stream got=%b %h %h want=1 %h %h", u_if.if_valid, u_if.if_pc,
                 u_if.if_instr, exp_pc, instr_of(exp_pc));
      else n_pass++;
      exp_pc += 4;
      tick();
    end
  endtask

  task automatic test_redirect(input logic [31:0] target);
    logic [31:0] aligned;
    aligned = {target[31:2], 2'b00};
    u_if.if_ready = 1'b0;
    repeat (4) tick();
    redirect_valid = 1'b1; redirect_pc = target; u_if.if_ready = 1'b1;
    tick();
    redirect_valid = 1'b0; redirect_pc = $urandom;
    n_total++;
    if (Pc_out !== aligned) $display("FAIL redir_pc_out got=%h want=%h", Pc_out, aligned);
    else n_pass++;
    n_total++;
    if (u_if.if_valid !== 1'b0) $display("FAIL redir_flush got=%b want=0", u_if.if_valid);
    else n_pass++;
    tick();
    n_total++;
    if (u_if.if_valid !== 1'b0) $display("FAIL redir_gap got=%b want=0", u_if.if_valid);
    else n_pass++;
    tick();
    exp_pc = aligned;
    for (int i = 0; i < 4; i++) begin
      n_total++;
      if (u_if.if_valid !== 1'b1 || u_if.if_pc !== exp_pc || u_if.if_instr !== instr_of(exp_pc))
        $display("FAIL redir_stream got=%b %h %h want=1 %h %h", u_if.if_valid, u_if.if_pc,
                 u_if.if_instr, exp_pc, instr_of(exp_pc));
      else n_pass++;
      exp_pc += 4;
      tick();
    end
  endtask

  task automatic test_wrap();
    logic [31:0] exp2;
    int got;
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    exp2 = 32'hFFFF_FFF8;
    got = 0;
    for (int c = 0; c < 20 && got < 4; c++) begin
      if (u_if2.if_valid === 1'b1) begin
        n_total++;
        if (u_if2.if_pc !== exp2 || u_if2.if_instr !== instr_of(exp2))
          $display("FAIL wrap_stream got=%h %h want=%h %h", u_if2.if_pc, u_if2.if_instr, exp2, instr_of(exp2));
        else n_pass++;
        exp2 += 4;
        got++;
      end
      tick();
    end
    n_total++;
    if (got != 4) $display("FAIL wrap_timeout got=%0d want=4 transfers", got);
    else n_pass++;
  endtask

  task automatic test_reset_midstream();
    int got;
    u_if.if_ready = 1'b0;
    repeat (3) tick();
    rst = 1'b1; u_if.if_ready = 1'b1;
    tick();
    rst = 1'b0; u_if.if_ready = 1'b0;
    n_total++;
    if (u_if.if_valid !== 1'b0) $display("FAIL midrst_valid got=%b want=0", u_if.if_valid);
    else n_pass++;
    n_total++;
    if (Pc_out !== 32'h0) $display("FAIL midrst_pc got=%h want=00000000", Pc_out);
    else n_pass++;
    exp_pc = 32'h0;
    got = 0;
    for (int i = 0; i < 16; i++) begin
      u_if.if_ready = (i % 2) == 1;
      if (u_if.if_valid === 1'b1 && u_if.if_ready === 1'b1) begin
        n_total++;
        if (u_if.if_pc !== exp_pc || u_if.if_instr !== instr_of(exp_pc))
          $display("FAIL midrst_stream got=%h %h want=%h %h", u_if.if_pc, u_if.if_instr, exp_pc, instr_of(exp_pc));
        else n_pass++;
        exp_pc += 4;
        got++;
      end
      tick();
    end
    n_total++;
    if (got < 4) $display("FAIL midrst_progress got=%0d want>=4 transfers", got);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic        redir;
    logic [31:0] tgt;
    int          got;
    got = 0;
    for (int i = 0; i < 400; i++) begin
      u_if.if_ready  = ($urandom_range(0, 3) != 0);
      redir          = ($urandom_range(0, 19) == 0);
      tgt            = $urandom;
      redirect_valid = redir;
      redirect_pc    = tgt;
      if (!redir && u_if.if_valid === 1'b1 && u_if.if_ready === 1'b1) begin
        n_total++;
        if (u_if.if_pc !== exp_pc || u_if.if_instr !== instr_of(exp_pc))
          $display("FAIL rand_stream cyc=%0d got=%h %h want=%h %h", i, u_if.if_pc, u_if.if_instr,
                   exp_pc, instr_of(exp_pc));
        else n_pass++;
        exp_pc += 4;
        got++;
      end
      tick();
      if (redir) begin
        exp_pc = {tgt[31:2], 2'b00};
        n_total++;
        if (Pc_out !== exp_pc) $display("FAIL rand_redir_pc got=%h want=%h", Pc_out, exp_pc);
        else n_pass++;
      end
    end
    redirect_valid = 1'b0;
    n_total++;
    if (got < 100) $display("FAIL rand_progress got=%0d want>=100 transfers", got);
    else n_pass++;
  endtask

  initial begin
    u_if.if_ready  = 1'b0;
    u_if2.if_ready = 1'b1;
    test_reset();
    test_backpressure();
    test_redirect(32'h0000_0040);
    test_redirect(32'h0000_0043);
    test_wrap();
    test_reset_midstream();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

endmodule
